// File: rtl/axis_ifmap_ingress.sv
`default_nettype none
// ============================================================================
// Module   : axis_ifmap_ingress
// Brief    : AXI4-Stream ifmap ingress with a 2-entry skid buffer, frame word
//            counting and abort flush. Option macro: AXIS_INGRESS_TLAST_CHECK_EN
// Revision : 1.0
// ============================================================================
module axis_ifmap_ingress #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_CNT_WIDTH      = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            start,
  input  logic                            abort,
  input  logic [FRAME_CNT_WIDTH-1:0]      frame_words,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] ifmaps_from_axis,
  output logic                            load_axis_preload,
  input  logic                            preload_ready,
  output logic                            axis_clear,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err_tlast
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [FRAME_CNT_WIDTH-1:0] c_cnt_zero = '0;
  localparam logic [FRAME_CNT_WIDTH-1:0] c_cnt_one  = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                            r_state;
  state_t                            w_state_next;
  logic [FRAME_CNT_WIDTH-1:0]        r_count;
  logic [FRAME_CNT_WIDTH-1:0]        r_in_cnt;
  logic [FRAME_CNT_WIDTH-1:0]        r_out_cnt;
  logic [1:0]                        r_occ;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_head;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_tail;
  logic                              r_frame_done;
  logic                              r_axis_clear;
  logic                              w_tready;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_last_pop;
  logic                              w_arm;
  logic                              w_frame_done_next;

  // Ready depends on registered state only, never on tvalid.
  assign w_tready   = (r_state == S_RUN) && (r_occ < 2'd2) && (r_in_cnt < r_count);
  assign w_push     = s_axis_tvalid && w_tready;
  assign w_pop      = (r_occ != 2'd0) && preload_ready;
  assign w_last_pop = w_pop && ((r_out_cnt + c_cnt_one) == r_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_arm             = 1'b0;
    w_frame_done_next = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (frame_words != c_cnt_zero) begin
              w_state_next = S_RUN;
              w_arm        = 1'b1;
            end else begin
              w_frame_done_next = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last_pop) begin
            w_state_next      = S_IDLE;
            w_frame_done_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_occ        <= 2'd0;
      r_head       <= '0;
      r_tail       <= '0;
      r_frame_done <= 1'b0;
      r_axis_clear <= 1'b0;
    end else if (abort) begin
      r_count      <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_occ        <= 2'd0;
      r_frame_done <= 1'b0;
      r_axis_clear <= 1'b1;
    end else begin
      r_axis_clear <= 1'b0;
      r_frame_done <= w_frame_done_next;
      if (w_arm) begin
        r_count   <= frame_words;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_push) r_in_cnt  <= r_in_cnt + c_cnt_one;
        if (w_pop)  r_out_cnt <= r_out_cnt + c_cnt_one;
        // Head is always the output word; tail is only used at occupancy 2.
        case ({w_push, w_pop})
          2'b10: begin
            if (r_occ == 2'd0) r_head <= s_axis_tdata;
            else               r_tail <= s_axis_tdata;
            r_occ <= r_occ + 2'd1;
          end
          2'b01: begin
            if (r_occ == 2'd2) r_head <= r_tail;
            r_occ <= r_occ - 2'd1;
          end
          2'b11: begin
            r_head <= s_axis_tdata;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef AXIS_INGRESS_TLAST_CHECK_EN
  logic r_err_tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_tlast <= 1'b0;
    end else if (!abort) begin
      if (w_arm) begin
        r_err_tlast <= 1'b0;
      end else if (w_push && (s_axis_tlast != ((r_in_cnt + c_cnt_one) == r_count))) begin
        r_err_tlast <= 1'b1;
      end
    end
  end

  assign err_tlast = r_err_tlast;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign err_tlast      = 1'b0;
`endif

  assign s_axis_tready     = w_tready;
  assign ifmaps_from_axis  = r_head;
  assign load_axis_preload = (r_occ != 2'd0);
  assign axis_clear        = r_axis_clear;
  assign busy              = (r_state == S_RUN);
  assign frame_done        = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_axis_ifmap_ingress.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_ifmap_ingress
// Brief    : Scoreboard bench for axis_ifmap_ingress against a queue model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axis_ifmap_ingress;

  localparam int DW = 32;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] frame_words = '0;
  logic [DW-1:0] ifmaps_from_axis;
  logic          load_axis_preload;
  logic          preload_ready = 1'b0;
  logic          axis_clear;
  logic          busy;
  logic          frame_done;
  logic          err_tlast;

  axis_ifmap_ingress #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .FRAME_CNT_WIDTH     (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .start            (start),
    .abort            (abort),
    .frame_words      (frame_words),
    .ifmaps_from_axis (ifmaps_from_axis),
    .load_axis_preload(load_axis_preload),
    .preload_ready    (preload_ready),
    .axis_clear       (axis_clear),
    .busy             (busy),
    .frame_done       (frame_done),
    .err_tlast        (err_tlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_prob = 100;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: frame state plus a queue of words in flight.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_hold  = '0;
  bit            m_run   = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_clear = 1'b0;
  bit            m_err   = 1'b0;
  int            m_cnt   = 0;
  int            m_in    = 0;
  int            m_out   = 0;

  initial begin : monitor
    logic          exp_tready;
    logic          exp_load;
    logic [DW-1:0] exp_data;
    forever begin
      @(negedge clk);
      exp_tready = m_run && (m_q.size() < 2) && (m_in < m_cnt);
      exp_load   = (m_q.size() != 0);
      exp_data   = exp_load ? m_q[0] : m_hold;
      chk("tready", s_axis_tready, exp_tready);
      chk("load", load_axis_preload, exp_load);
      chk("data", ifmaps_from_axis, exp_data);
      chk("busy", busy, m_run);
      chk("frame_done", frame_done, m_done);
      chk("axis_clear", axis_clear, m_clear);
      chk("err_tlast", err_tlast, m_err);
      if (!rst_n) begin
        m_q.delete();
        m_hold = '0; m_run = 0; m_done = 0; m_clear = 0; m_err = 0;
        m_cnt = 0; m_in = 0; m_out = 0;
      end else if (abort) begin
        if (m_q.size() != 0) m_hold = m_q[0];
        m_q.delete();
        m_run = 0; m_done = 0; m_clear = 1; m_cnt = 0; m_in = 0; m_out = 0;
      end else begin
        m_clear = 0;
        m_done  = 0;
        if (!m_run) begin
          if (start) begin
            if (frame_words != '0) begin
              m_run = 1; m_cnt = int'(frame_words); m_in = 0; m_out = 0; m_err = 0;
            end else begin
              m_done = 1;
            end
          end
        end else begin
          if (exp_load && preload_ready) begin
            m_hold = m_q.pop_front();
            m_out++;
            if (m_out == m_cnt) begin
              m_run = 0; m_done = 1;
            end
          end
          if (s_axis_tvalid && exp_tready) begin
`ifdef AXIS_INGRESS_TLAST_CHECK_EN
            if (s_axis_tlast != (m_in + 1 == m_cnt)) m_err = 1;
`endif
            m_q.push_back(s_axis_tdata);
            m_in++;
          end
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #2;
      preload_ready = ($urandom_range(99) < rdy_prob);
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    frame_words = n[CW-1:0];
    tick();
    start = 1'b0;
  endtask

  // Sends n_send beats of a frame_n-word frame; bad_idx flips tlast on that beat.
  task automatic send_beats(input int n_send, input int frame_n, input int vprob,
                            input int bad_idx, input int extra, input bit rand_start);
    int   idx = 0;
    int   cyc = 0;
    logic acc = 1'b0;
    while (idx < n_send && cyc < 2000) begin
      if (!(s_axis_tvalid && !acc)) begin
        s_axis_tvalid = ($urandom_range(99) < vprob);
        s_axis_tdata  = $urandom();
      end
      s_axis_tlast = (idx == frame_n - 1) ^ (idx == bad_idx);
      if (rand_start) begin
        start       = ($urandom_range(7) == 0);
        frame_words = CW'($urandom_range(1, 9));
      end
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    start = 1'b0;
    chk("beat_budget", idx, n_send);
    s_axis_tvalid = (extra > 0);
    s_axis_tlast  = 1'b0;
    repeat (extra) tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 500) begin
      tick();
      c++;
    end
    chk("idle_budget", busy, 1'b0);
    tick();
  endtask

  initial begin : stimulus
    int n;
    int bad;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full-rate 4-word frame, then hold tvalid to probe tready past the frame end.
    rdy_prob = 100;
    do_start(4);
    send_beats(4, 4, 100, -1, 3, 1'b0);
    wait_idle();

    // Downstream stall builds occupancy 2.
    do_start(6);
    fork
      send_beats(6, 6, 100, -1, 0, 1'b0);
      begin
        tick();
        rdy_prob = 0;
        repeat (4) tick();
        rdy_prob = 100;
      end
    join
    wait_idle();

    // Early tlast on beat 2, then a clean frame that must clear the flag.
    do_start(3);
    send_beats(3, 3, 100, 1, 0, 1'b0);
    wait_idle();
    repeat (2) tick();
    do_start(2);
    send_beats(2, 2, 100, -1, 0, 1'b0);
    wait_idle();

    // Abort with one word held.
    do_start(8);
    send_beats(3, 8, 100, -1, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();

    // Zero-length frame, then reset mid-frame.
    do_start(0);
    repeat (3) tick();
    do_start(5);
    send_beats(2, 5, 100, -1, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized frames with stray starts during RUN.
    for (int f = 0; f < 12; f++) begin
      n        = $urandom_range(1, 16);
      bad      = ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : -1;
      rdy_prob = $urandom_range(20, 100);
      do_start(n);
      send_beats(n, n, $urandom_range(30, 100), bad, 0, 1'b1);
      wait_idle();
    end

    rdy_prob = 100;
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
